// File: rtl/printer_pkg.sv
// printer_pkg: shared types and default constants for the printer receiver.
//   PRINTER_DATA_W         width of a printer data byte
//   PRINTER_COUNT_W        width of the printed-character counter
//   PRINTER_DEPTH          default FIFO depth
//   PRINTER_PRINT_CYCLES   default cycles spent printing one character
//   PRINTER_HOLD_CYCLES    default minimum RDY-low time after an accept
//   print_state_e          print engine states
package printer_pkg;

   localparam int unsigned PRINTER_DATA_W       = 8;
   localparam int unsigned PRINTER_COUNT_W      = 16;
   localparam int unsigned PRINTER_DEPTH        = 4;
   localparam int unsigned PRINTER_PRINT_CYCLES = 8;
   localparam int unsigned PRINTER_HOLD_CYCLES  = 2;

   typedef logic [PRINTER_DATA_W-1:0] pdata_t;

   typedef enum logic {
      P_IDLE  = 1'b0,
      P_PRINT = 1'b1
   } print_state_e;

endpackage

// File: rtl/printer_fifo.sv
// printer_fifo: synchronous FIFO for received printer bytes.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
// The caller must not push when full or pop when empty.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_data   write strobe and byte
//   i_pop            read strobe; o_data_c shows the head entry
//   o_full_c         all DEPTH entries occupied
//   o_empty_c        no entries occupied
//   o_count_c        current occupancy, 0..DEPTH
module printer_fifo
   import printer_pkg::*;
#(
   parameter int unsigned DEPTH = PRINTER_DEPTH,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_push,
   input  pdata_t        i_data,
   input  logic          i_pop,
   output pdata_t        o_data_c,
   output logic          o_full_c,
   output logic          o_empty_c,
   output logic [AW:0]   o_count_c
);

   pdata_t        mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;

   // Pointer update
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (i_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (i_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage; contents are don't-care until written
   always_ff @(posedge i_clk) begin
      if (i_push) mem[wr_ptr[AW-1:0]] <= i_data;
   end

   assign o_data_c  = mem[rd_ptr[AW-1:0]];
   assign o_empty_c = (wr_ptr == rd_ptr);
   assign o_full_c  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign o_count_c = wr_ptr - rd_ptr;

endmodule

// File: rtl/printer_rx.sv
// printer_rx: printer-side receiver for the parallel output port.
// Accepts a byte on each i_tr pulse seen while o_rdy is high, buffers it
// in a FIFO, and prints one character every PRINT_CYCLES+1 cycles.
// Optional feature macro: PRINTER_RX_ERR_EN enables the sticky o_err flag
// raised by a strobe arriving while o_rdy is low; otherwise o_err is 0.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_tr, i_pd       transfer strobe and data byte from the controller
//   o_rdy            printer ready; low for HOLD_CYCLES after each accept
//                    and whenever the FIFO is full
//   o_char           last printed character
//   o_char_valid     one-cycle pulse per printed character
//   o_count          characters printed since reset, wrapping
//   o_err            sticky protocol error
module printer_rx
   import printer_pkg::*;
#(
   parameter int unsigned DEPTH        = PRINTER_DEPTH,
   parameter int unsigned PRINT_CYCLES = PRINTER_PRINT_CYCLES,
   parameter int unsigned HOLD_CYCLES  = PRINTER_HOLD_CYCLES
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_tr,
   input  logic [PRINTER_DATA_W-1:0]   i_pd,
   output logic                        o_rdy,
   output logic [PRINTER_DATA_W-1:0]   o_char,
   output logic                        o_char_valid,
   output logic [PRINTER_COUNT_W-1:0]  o_count,
   output logic                        o_err
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned PCW = (PRINT_CYCLES > 1) ? $clog2(PRINT_CYCLES) : 1;
   localparam int unsigned HCW = $clog2(HOLD_CYCLES + 1);

   print_state_e   state;
   logic [PCW-1:0] print_cnt;
   logic [HCW-1:0] hold_cnt;
   logic [HCW-1:0] hold_next;
   logic [AW:0]    occ;
   logic [AW:0]    occ_next;
   logic           fifo_full;
   logic           fifo_empty;
   pdata_t         fifo_data;
   logic           push;
   logic           pop;

   // A strobe only counts while ready; full guard is belt-and-braces
   assign push = i_tr && o_rdy && !fifo_full;
   assign pop  = (state == P_IDLE) && !fifo_empty;

   printer_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_push    (push),
      .i_data    (i_pd),
      .i_pop     (pop),
      .o_data_c  (fifo_data),
      .o_full_c  (fifo_full),
      .o_empty_c (fifo_empty),
      .o_count_c (occ)
   );

   // Hold counter: reload on accept, otherwise count down and saturate at 0
   always_comb begin
      hold_next = hold_cnt;
      if (push) begin
         hold_next = HCW'(HOLD_CYCLES);
      end else if (hold_cnt != '0) begin
         hold_next = hold_cnt - HCW'(1);
      end
   end

   // Occupancy after this cycle's push/pop decides whether RDY may rise
   assign occ_next = occ + (AW+1)'(push) - (AW+1)'(pop);

   // RDY register and hold counter
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hold_cnt <= '0;
         o_rdy    <= 1'b1;
      end else begin
         hold_cnt <= hold_next;
         o_rdy    <= (hold_next == '0) && (occ_next < (AW+1)'(DEPTH));
      end
   end

   // Print engine: pop a byte, spend PRINT_CYCLES cycles, then strobe it out
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= P_IDLE;
         print_cnt    <= '0;
         o_char       <= '0;
         o_char_valid <= 1'b0;
         o_count      <= '0;
      end else begin
         o_char_valid <= 1'b0;
         case (state)
            P_IDLE: begin
               if (!fifo_empty) begin
                  o_char    <= fifo_data;
                  print_cnt <= PCW'(PRINT_CYCLES - 1);
                  state     <= P_PRINT;
               end
            end
            P_PRINT: begin
               if (print_cnt == '0) begin
                  o_char_valid <= 1'b1;
                  o_count      <= o_count + PRINTER_COUNT_W'(1);
                  state        <= P_IDLE;
               end else begin
                  print_cnt <= print_cnt - PCW'(1);
               end
            end
            default: state <= P_IDLE;
         endcase
      end
   end

`ifdef PRINTER_RX_ERR_EN
   // Sticky flag for a strobe the controller sent while we were not ready
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_err <= 1'b0;
      end else if (i_tr && !o_rdy) begin
         o_err <= 1'b1;
      end
   end
`else
   assign o_err = 1'b0;
`endif

endmodule
